// File: rtl/vga_fb_ctrl_if.sv
// Drawer write port of the VGA double-buffered framebuffer controller.
// The drawer holds wr_req with address/data until wr_ack; wr_err flags an out-of-range address.
interface vga_fb_ctrl_if #(
  parameter int unsigned DW = 8
) ();
  logic          wr_req;
  logic [15:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          wr_err;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_ack,
    input  wr_err
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_ack,
    output wr_err
  );
endinterface

// File: rtl/vga_fb_ctrl.sv
// Double-buffered VGA framebuffer controller sharing one single-port RAM between display and drawer.
// Define VGA_FB_CTRL_CLEAR_EN to zero-fill the new back bank after every swap.
module vga_fb_ctrl #(
  parameter int unsigned W  = 320,
  parameter int unsigned H  = 180,
  parameter int unsigned DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pix_stb,
  input  logic          i_active,
  input  logic          i_animate,
  input  logic [9:0]    i_x,
  input  logic [8:0]    i_y,
  vga_fb_ctrl_if.slave  io_wr,
  input  logic          i_swap_req,
  output logic          o_swap_done,
  output logic          o_busy,
  output logic          o_front,
  output logic [16:0]   o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [DW-1:0] o_pix
);

  localparam logic [16:0] NumPix = 17'(W * H);

`ifdef VGA_FB_CTRL_CLEAR_EN
  typedef enum logic [1:0] {StIdle, StPend, StClear} state_e;
`else
  typedef enum logic [0:0] {StIdle, StPend} state_e;
`endif

  state_e        r_state;
  logic          r_front;
  logic          r_swap_done;
  logic          r_rg_d;
  logic          r_blank_d;
  logic [DW-1:0] r_pix;

  logic          w_rg;
  logic          w_clearing;
  logic          w_grant;
  logic          w_in_range;
  logic [15:0]   w_rd_pix;

  assign w_rg = i_pix_stb & i_active;

  // Display address y*W+x; the common 320-wide case avoids a multiplier.
  if (W == 320) begin : g_shift_add
    assign w_rd_pix = ({7'd0, i_y} << 8) + ({7'd0, i_y} << 6) + {6'd0, i_x};
  end else begin : g_mult
    assign w_rd_pix = 16'(32'(i_y) * W) + {6'd0, i_x};
  end

`ifdef VGA_FB_CTRL_CLEAR_EN
  logic [15:0] r_cnt;
  logic        w_clr_last;
  logic        w_clr_wr;

  assign w_clearing = (r_state == StClear);
  assign w_clr_last = ({1'b0, r_cnt} == (NumPix - 17'd1));
  assign w_clr_wr   = ~i_rst & w_clearing & ~w_rg;
`else
  assign w_clearing = 1'b0;
`endif

  assign w_grant    = ~i_rst & ~w_rg & io_wr.wr_req & ~w_clearing;
  assign w_in_range = ({1'b0, io_wr.wr_addr} < NumPix);

  assign io_wr.wr_ack = w_grant;
  assign io_wr.wr_err = w_grant & ~w_in_range;

  // Display read always wins the RAM port; drawer writes target the back bank.
  always_comb begin
    o_mem_addr  = {~r_front, io_wr.wr_addr};
    o_mem_wdata = io_wr.wr_data;
    o_mem_we    = w_grant & w_in_range;
    if (w_rg) begin
      o_mem_addr = {r_front, w_rd_pix};
      o_mem_we   = 1'b0;
    end
`ifdef VGA_FB_CTRL_CLEAR_EN
    else if (w_clearing) begin
      o_mem_addr  = {~r_front, r_cnt};
      o_mem_wdata = '0;
      o_mem_we    = w_clr_wr;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_front     <= 1'b0;
      r_swap_done <= 1'b0;
`ifdef VGA_FB_CTRL_CLEAR_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_swap_done <= 1'b0;
      case (r_state)
        StIdle: begin
          // A request coinciding with i_animate still waits for the next frame boundary.
          if (i_swap_req) r_state <= StPend;
        end
        StPend: begin
          if (i_animate) begin
            r_front     <= ~r_front;
            r_swap_done <= 1'b1;
`ifdef VGA_FB_CTRL_CLEAR_EN
            r_state     <= StClear;
            r_cnt       <= '0;
`else
            r_state     <= StIdle;
`endif
          end
        end
`ifdef VGA_FB_CTRL_CLEAR_EN
        StClear: begin
          if (!w_rg) begin
            if (w_clr_last) begin
              r_state <= StIdle;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  // RAM data lands one cycle after the read grant and is captured the cycle after that.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rg_d    <= 1'b0;
      r_blank_d <= 1'b0;
      r_pix     <= '0;
    end else begin
      r_rg_d    <= w_rg;
      r_blank_d <= ~w_rg & ~i_active;
      if (r_rg_d) begin
        r_pix <= i_mem_rdata;
      end else if (r_blank_d) begin
        r_pix <= '0;
      end
    end
  end

  assign o_busy      = ~i_rst & (r_state != StIdle);
  assign o_front     = r_front;
  assign o_swap_done = r_swap_done;
  assign o_pix       = r_pix;

endmodule
